// File: rtl/dma_ctrl.sv
// Word-copy DMA engine: requests the dmem bus via hold/holdACK, then copies LEN words SRC->DST.
// Two cycles per word under steady grant; losing holdACK mid-word retries that word from READ.
module dma_ctrl #(
  parameter int wide = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      addr,
  input  logic [31:0]     dataIn,
  input  logic            holdACK,
  input  logic [wide-1:0] dm_q,
  output logic            hold,
  output logic [31:0]     dm_a,
  output logic [wide-1:0] dm_d,
  output logic            dm_we,
  output logic            busy,
  output logic            done,
  output logic            irq
);

  localparam logic [4:0] A_SRC  = 5'b11000;
  localparam logic [4:0] A_DST  = 5'b11001;
  localparam logic [4:0] A_LEN  = 5'b11010;
  localparam logic [4:0] A_CTRL = 5'b11011;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_REL   = 3'd4;

  logic [2:0]      state;
  logic [31:0]     src_reg, dst_reg, len_reg;
  logic [31:0]     src_w, dst_w, cnt_w;
  logic [wide-1:0] buf_q;

  logic cfg_wr, start_wr, clr_wr, complete;

  always_comb begin
    cfg_wr   = we && (state == S_IDLE);
    start_wr = cfg_wr && (addr == A_CTRL) && dataIn[0];
    // Clear-done is accepted even while busy.
    clr_wr   = we && (addr == A_CTRL) && dataIn[1];
    complete = (start_wr && (len_reg == 32'd0)) ||
               ((state == S_REL) && !holdACK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      src_reg <= '0;
      dst_reg <= '0;
      len_reg <= '0;
      src_w   <= '0;
      dst_w   <= '0;
      cnt_w   <= '0;
      buf_q   <= '0;
      done    <= 1'b0;
      irq     <= 1'b0;
    end else begin
      irq <= complete;
      // Completion beats a simultaneous clear.
      if (complete)    done <= 1'b1;
      else if (clr_wr) done <= 1'b0;

      if (cfg_wr) begin
        case (addr)
          A_SRC:   src_reg <= {dataIn[31:2], 2'b00};
          A_DST:   dst_reg <= {dataIn[31:2], 2'b00};
          A_LEN:   len_reg <= dataIn;
          default: ;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (start_wr && (len_reg != 32'd0)) begin
            state <= S_REQ;
            src_w <= src_reg;
            dst_w <= dst_reg;
            cnt_w <= len_reg;
          end
        end
        S_REQ: begin
          if (holdACK) state <= S_READ;
        end
        S_READ: begin
          if (!holdACK) begin
            state <= S_REQ;
          end else begin
            buf_q <= dm_q;
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (!holdACK) begin
            state <= S_REQ;
          end else begin
            src_w <= src_w + 32'd4;
            dst_w <= dst_w + 32'd4;
            if (cnt_w != 32'd0) cnt_w <= cnt_w - 32'd1;
            state <= (cnt_w <= 32'd1) ? S_REL : S_READ;
          end
        end
        S_REL: begin
          if (!holdACK) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    hold  = (state == S_REQ) || (state == S_READ) || (state == S_WRITE);
    busy  = (state != S_IDLE);
    dm_we = (state == S_WRITE) && holdACK;
    dm_a  = 32'd0;
    dm_d  = '0;
    if (state == S_READ) begin
      dm_a = src_w;
    end else if (state == S_WRITE) begin
      dm_a = dst_w;
      dm_d = buf_q;
    end
  end

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench for dma_ctrl with a one-cycle-latency grant model and an XOR-pattern dmem.
module tb_dma_ctrl;

  localparam logic [4:0]  A_SRC  = 5'b11000;
  localparam logic [4:0]  A_DST  = 5'b11001;
  localparam logic [4:0]  A_LEN  = 5'b11010;
  localparam logic [4:0]  A_CTRL = 5'b11011;
  localparam logic [31:0] KEY    = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] dataIn = '0;
  logic        holdACK = 1'b0;
  logic [31:0] dm_q;
  logic        hold, dm_we, busy, done, irq;
  logic [31:0] dm_a, dm_d;

  int checks = 0;
  int errors = 0;

  logic        grant_en = 1'b1;
  logic        hold_d = 1'b0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  int          irq_cnt = 0;
  int          hold_cnt = 0;
  int          cyc = 0;

  dma_ctrl #(.wide(32)) dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .dataIn(dataIn),
    .holdACK(holdACK), .dm_q(dm_q), .hold(hold), .dm_a(dm_a), .dm_d(dm_d),
    .dm_we(dm_we), .busy(busy), .done(done), .irq(irq)
  );

  always #5 clk = ~clk;

  assign dm_q = dm_a ^ KEY;

  // Grant follows hold one cycle later; grant_en models the decoder taking the bus away.
  always @(negedge clk) begin
    holdACK = grant_en & hold_d;
    hold_d  = hold;
  end

  // Values here are stable until the next rising edge, i.e. what the DUT commits.
  always @(negedge clk) begin
    #1;
    cyc++;
    if (dm_we) begin
      wa.push_back(dm_a);
      wd.push_back(dm_d);
      wc.push_back(cyc);
    end
    if (irq) irq_cnt++;
    if (hold) hold_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic cfg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; dataIn = d;
    @(negedge clk);
    we = 1'b0; addr = '0; dataIn = '0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin errors++; $display("FAIL %s_idle_timeout busy=%b exp 0", nm, busy); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    #2;
    checks++; if (hold !== 1'b0)   begin errors++; $display("FAIL rst_hold got %b exp 0", hold); end
    checks++; if (dm_we !== 1'b0)  begin errors++; $display("FAIL rst_dm_we got %b exp 0", dm_we); end
    checks++; if (dm_a !== 32'd0)  begin errors++; $display("FAIL rst_dm_a got %h exp 0", dm_a); end
    checks++; if (dm_d !== 32'd0)  begin errors++; $display("FAIL rst_dm_d got %h exp 0", dm_d); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL rst_done got %b exp 0", done); end
    checks++; if (irq !== 1'b0)    begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_copy;
    int w0 = wa.size();
    int i0 = irq_cnt;
    cfg(A_SRC, 32'h100); cfg(A_DST, 32'h200); cfg(A_LEN, 32'd3); cfg(A_CTRL, 32'd1);
    wait_idle("basic");
    checks++;
    if (wa.size() - w0 != 3) begin errors++; $display("FAIL basic_wr_count got %0d exp 3", wa.size() - w0); end
    if (wa.size() - w0 == 3) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (wa[w0+k] !== 32'h200 + 32'(4*k)) begin errors++; $display("FAIL basic_addr%0d got %h exp %h", k, wa[w0+k], 32'h200 + 32'(4*k)); end
        checks++;
        if (wd[w0+k] !== ((32'h100 + 32'(4*k)) ^ KEY)) begin errors++; $display("FAIL basic_data%0d got %h exp %h", k, wd[w0+k], (32'h100 + 32'(4*k)) ^ KEY); end
        if (k > 0) begin
          checks++;
          if (wc[w0+k] - wc[w0+k-1] != 2) begin errors++; $display("FAIL basic_spacing%0d got %0d exp 2", k, wc[w0+k] - wc[w0+k-1]); end
        end
      end
    end
    checks++; if (irq_cnt - i0 != 1) begin errors++; $display("FAIL basic_irq_cycles got %0d exp 1", irq_cnt - i0); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done got %b exp 1", done); end
    checks++; if (hold !== 1'b0) begin errors++; $display("FAIL basic_hold got %b exp 0", hold); end
  endtask

  task automatic test_len_zero;
    int h0;
    cfg(A_CTRL, 32'd2);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL len0_clear got %b exp 0", done); end
    cfg(A_LEN, 32'd0);
    h0 = hold_cnt;
    cfg(A_CTRL, 32'd1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL len0_irq got %b exp 1", irq); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL len0_done got %b exp 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy got %b exp 0", busy); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL len0_irq_end got %b exp 0", irq); end
    checks++; if (hold_cnt != h0) begin errors++; $display("FAIL len0_hold got %0d exp %0d", hold_cnt, h0); end
    cfg(A_CTRL, 32'd2);
    cfg(A_CTRL, 32'd3);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL len0_clear_vs_done got %b exp 1", done); end
  endtask

  task automatic test_grant_loss;
    int w0 = wa.size();
    int n = 0;
    cfg(A_SRC, 32'h400); cfg(A_DST, 32'h500); cfg(A_LEN, 32'd4); cfg(A_CTRL, 32'd1);
    while ((wa.size() - w0) < 1 && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    checks++;
    if ((wa.size() - w0) < 1) begin errors++; $display("FAIL gl_first_write_timeout got %0d exp 1", wa.size() - w0); end
    @(posedge clk);
    @(posedge clk);
    #2 grant_en = 1'b0;
    repeat (3) @(posedge clk);
    #2 grant_en = 1'b1;
    wait_idle("gl");
    checks++;
    if (wa.size() - w0 != 4) begin errors++; $display("FAIL gl_wr_count got %0d exp 4", wa.size() - w0); end
    if (wa.size() - w0 == 4) begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (wa[w0+k] !== 32'h500 + 32'(4*k)) begin errors++; $display("FAIL gl_addr%0d got %h exp %h", k, wa[w0+k], 32'h500 + 32'(4*k)); end
        checks++;
        if (wd[w0+k] !== ((32'h400 + 32'(4*k)) ^ KEY)) begin errors++; $display("FAIL gl_data%0d got %h exp %h", k, wd[w0+k], (32'h400 + 32'(4*k)) ^ KEY); end
      end
    end
  endtask

  task automatic test_reset_mid;
    int w0 = wa.size();
    int i0 = irq_cnt;
    int h0;
    cfg(A_SRC, 32'h600); cfg(A_DST, 32'h700); cfg(A_LEN, 32'd2); cfg(A_CTRL, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (hold !== 1'b0) begin errors++; $display("FAIL rmid_hold got %b exp 0", hold); end
    checks++; if (dm_a !== 32'd0) begin errors++; $display("FAIL rmid_dm_a got %h exp 0", dm_a); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (wa.size() != w0) begin errors++; $display("FAIL rmid_writes got %0d exp %0d", wa.size(), w0); end
    checks++; if (irq_cnt != i0) begin errors++; $display("FAIL rmid_irq got %0d exp %0d", irq_cnt, i0); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done got %b exp 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
    h0 = hold_cnt;
    cfg(A_CTRL, 32'd1);
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rmid_len_cleared got %b exp 1", done); end
    checks++; if (hold_cnt != h0) begin errors++; $display("FAIL rmid_len_hold got %0d exp %0d", hold_cnt, h0); end
  endtask

  task automatic test_wrap_align;
    int w0 = wa.size();
    cfg(A_SRC, 32'hFFFF_FFFC); cfg(A_DST, 32'h800); cfg(A_LEN, 32'd2); cfg(A_CTRL, 32'd1);
    wait_idle("wrap");
    checks++;
    if (wa.size() - w0 != 2) begin errors++; $display("FAIL wrap_wr_count got %0d exp 2", wa.size() - w0); end
    if (wa.size() - w0 == 2) begin
      checks++; if (wd[w0] !== (32'hFFFF_FFFC ^ KEY)) begin errors++; $display("FAIL wrap_data0 got %h exp %h", wd[w0], 32'hFFFF_FFFC ^ KEY); end
      checks++; if (wd[w0+1] !== KEY) begin errors++; $display("FAIL wrap_data1 got %h exp %h", wd[w0+1], KEY); end
      checks++; if (wa[w0+1] !== 32'h804) begin errors++; $display("FAIL wrap_addr1 got %h exp 00000804", wa[w0+1]); end
    end
    w0 = wa.size();
    cfg(A_SRC, 32'h103); cfg(A_DST, 32'h20B); cfg(A_LEN, 32'd1); cfg(A_CTRL, 32'd1);
    wait_idle("align");
    checks++;
    if (wa.size() - w0 != 1) begin errors++; $display("FAIL align_wr_count got %0d exp 1", wa.size() - w0); end
    if (wa.size() - w0 == 1) begin
      checks++; if (wa[w0] !== 32'h208) begin errors++; $display("FAIL align_addr got %h exp 00000208", wa[w0]); end
      checks++; if (wd[w0] !== (32'h100 ^ KEY)) begin errors++; $display("FAIL align_data got %h exp %h", wd[w0], 32'h100 ^ KEY); end
    end
  endtask

  task automatic test_busy_writes;
    int w0 = wa.size();
    cfg(A_SRC, 32'hA00); cfg(A_DST, 32'hB00); cfg(A_LEN, 32'd2); cfg(A_CTRL, 32'd1);
    cfg(A_LEN, 32'd5); cfg(A_CTRL, 32'd1); cfg(A_SRC, 32'hC00);
    wait_idle("busy1");
    checks++; if (wa.size() - w0 != 2) begin errors++; $display("FAIL busy_wr_count got %0d exp 2", wa.size() - w0); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL busy_done got %b exp 1", done); end
    w0 = wa.size();
    cfg(A_CTRL, 32'd1);
    cfg(A_CTRL, 32'd2);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL busy_clear got %b exp 0", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_during got %b exp 1", busy); end
    wait_idle("busy2");
    checks++; if (wa.size() - w0 != 2) begin errors++; $display("FAIL busy_rerun_count got %0d exp 2", wa.size() - w0); end
    if (wa.size() - w0 == 2) begin
      checks++; if (wd[w0] !== (32'hA00 ^ KEY)) begin errors++; $display("FAIL busy_src_kept got %h exp %h", wd[w0], 32'hA00 ^ KEY); end
    end
    cfg(A_CTRL, 32'd2);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL busy_final_clear got %b exp 0", done); end
  endtask

  initial begin
    test_reset;
    test_basic_copy;
    test_len_zero;
    test_grant_loss;
    test_reset_mid;
    test_wrap_align;
    test_busy_writes;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_ctrl.md
DMA_CTRL -- requirements
Module: dma_ctrl

Interface
REQ-001 Parameter wide, default 32, SHALL set the data-word width of the dmem-side data ports and the copy buffer.
REQ-002 Port clk, input, 1: the single clock; all state SHALL update on the rising edge only.
REQ-003 Port rst, input, 1: asynchronous, active-low reset; rst=0 SHALL force reset state immediately, independent of clk.
REQ-004 Port we, input, 1: CPU configuration write strobe, sampled on the clk edge.
REQ-005 Port addr, input, 5: configuration register select.
REQ-006 Port dataIn, input, 32: configuration write data.
REQ-007 Port holdACK, input, 1: bus grant from the CPU decoder; high means the dmem bus is owned by this block.
REQ-008 Port dm_q, input, wide: dmem read data, combinational from dm_a.
REQ-009 Port hold, output, 1: bus request to the CPU decoder.
REQ-010 Port dm_a, output, 32: dmem byte address.
REQ-011 Port dm_d, output, wide: dmem write data.
REQ-012 Port dm_we, output, 1: dmem write enable.
REQ-013 Port busy, output, 1: high in any state other than IDLE.
REQ-014 Port done, output, 1: sticky completion flag.
REQ-015 Port irq, output, 1: one-cycle completion pulse.

Function
REQ-016 Config map, written when we=1: 5'b11000 SRC; 5'b11001 DST; 5'b11010 LEN, in words, 32 bits; 5'b11011 CTRL, where bit0=start and bit1=clear done; all other addresses SHALL be ignored.
REQ-017 SRC and DST writes SHALL force bits [1:0] to 0, so addresses are always word aligned.
REQ-018 Config writes while busy=1 SHALL be ignored, including start; a CTRL clear-done write SHALL be honoured in any state.
REQ-019 FSM states: IDLE, REQ, READ, WRITE, REL; the reset state is IDLE.
REQ-020 IDLE: a start write with LEN!=0 SHALL go to REQ on that edge, loading working copies of SRC, DST and LEN; a start write with LEN==0 SHALL stay in IDLE, set done, and pulse irq the next cycle.
REQ-021 REQ: hold=1; the FSM SHALL move to READ on the first edge where holdACK=1.
REQ-022 READ: hold=1, dm_a=working src, dm_we=0; on the edge the FSM SHALL capture dm_q into the buffer and go to WRITE.
REQ-023 WRITE: hold=1, dm_a=working dst, dm_d=buffer, dm_we=holdACK. On the edge: src+=4, dst+=4, count-=1; go to REL if count was 1, else to READ.
REQ-024 Steady grant timing: exactly 2 cycles per word, with dm_we high for exactly 1 cycle per word.
REQ-025 Grant loss: if holdACK=0 in READ or WRITE, the FSM SHALL go to REQ with no pointer or count change, so the in-flight word is fully retried and no dm_we is issued.
REQ-026 REL: hold=0; the FSM SHALL go to IDLE on the first edge where holdACK=0, set done, and assert irq for exactly the following cycle.
REQ-027 Address arithmetic SHALL wrap modulo 2^32; the count SHALL never underflow.
REQ-028 Outside READ and WRITE: dm_we=0, dm_a=0, dm_d=0.
REQ-029 A clear-done write in the same cycle as completion SHALL leave done=1, because completion wins.

Reset
REQ-030 While rst=0: FSM in IDLE; hold=0, dm_we=0, dm_a=0, dm_d=0, busy=0, done=0, irq=0; SRC, DST, LEN and the working copies SHALL all be 0.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer with no further dm_we, no done and no irq, and SHALL drop hold asynchronously.

Verification
REQ-032 SRC=0x100, DST=0x200, LEN=3, start, holdACK returned 1 cycle after hold -> dm_we pulses at dm_a 0x200/0x204/0x208 with the data from 0x100/0x104/0x108; the pulses are 2 cycles apart; hold drops; irq is 1 cycle; done=1.
REQ-033 LEN=0 start -> no hold, done=1, and a single irq pulse one cycle after the start write.
REQ-034 holdACK deasserted during the WRITE of word 2 of 4, then regranted 3 cycles later -> word 2 is re-read and written exactly once; total dm_we count is 4.
REQ-035 rst=0 pulsed during READ of word 1 -> hold=0 immediately; no dm_we; after release done=0 and busy=0.
REQ-036 SRC=0xFFFFFFFC, LEN=2 -> second read at 0x00000000 (wrap); SRC written as 0x103 reads back into the copy as 0x100.
REQ-037 Start rewritten while busy -> ignored; clear-done written after completion -> done=0.
